// File: rtl/cache_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_arb_pkg
// Description : Shared types and constants for the cache bus arbiter:
//               FSM state encoding, master IDs and a granted-request helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_arb_pkg;

    // Transaction sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_t;

    // Master identifiers held in the grant register
    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    // Request line of whichever master currently owns the grant
    function automatic logic gnt_req(input logic gnt,
                                     input logic inst_req,
                                     input logic data_req);
        return (gnt == GNT_DATA) ? data_req : inst_req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : cache_arb_pick
// Description : Combinational winner selection between the i-cache and
//               d-cache requests. Fixed data priority by default; with
//               CACHE_ARB_RR_EN defined, simultaneous requests go to the
//               master that was not granted last.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arb_pick
    import cache_arb_pkg::*;
(
    input  logic inst_req,
    input  logic data_req,
`ifdef CACHE_ARB_RR_EN
    input  logic last_gnt,
`endif
    output logic winner
);

    // Pick the winner; with no request at all the result defaults to data
    always_comb begin
        winner = GNT_DATA;
`ifdef CACHE_ARB_RR_EN
        if (inst_req && data_req) begin
            winner = (last_gnt == GNT_DATA) ? GNT_INST : GNT_DATA;
        end else if (inst_req) begin
            winner = GNT_INST;
        end
`else
        if (!data_req && inst_req) begin
            winner = GNT_INST;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/cache_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_bus_arbiter
// Description : Shares one sram-like bus to the AXI bridge between the
//               i-cache and d-cache masters. One transaction outstanding at
//               a time, sequenced IDLE -> ADDR -> DATA. Optional macro
//               CACHE_ARB_RR_EN enables round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_bus_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
)(
    input  logic                  clk,
    input  logic                  rst,
    // i-cache master (read only)
    input  logic                  inst_req,
    input  logic [1:0]            inst_size,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    // d-cache master
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    // bridge side
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok
);

    state_t r_state_q, r_state_d;
    logic   r_gnt_q,   r_gnt_d;
    logic   w_winner;
    logic   w_gnt_req;
`ifdef CACHE_ARB_RR_EN
    logic   r_last_gnt_q, r_last_gnt_d;
`endif

    cache_arb_pick u_pick (
        .inst_req (inst_req),
`ifdef CACHE_ARB_RR_EN
        .last_gnt (r_last_gnt_q),
`endif
        .data_req (data_req),
        .winner   (w_winner)
    );

    assign w_gnt_req = gnt_req(r_gnt_q, inst_req, data_req);

    // Read data is shared by both masters; only data_ok qualifies it
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    // Next state: grant is only reloaded in IDLE; a dropped request in ADDR aborts
    always_comb begin
        r_state_d = r_state_q;
        r_gnt_d   = r_gnt_q;
`ifdef CACHE_ARB_RR_EN
        r_last_gnt_d = r_last_gnt_q;
`endif
        case (r_state_q)
            IDLE: begin
                if (inst_req || data_req) begin
                    r_gnt_d   = w_winner;
                    r_state_d = ADDR;
                end
            end
            ADDR: begin
                if (!w_gnt_req) begin
                    r_state_d = IDLE;
                end else if (mem_addr_ok) begin
                    r_state_d = DATA;
`ifdef CACHE_ARB_RR_EN
                    r_last_gnt_d = r_gnt_q;
`endif
                end
            end
            DATA: begin
                if (mem_data_ok) begin
                    r_state_d = IDLE;
                end
            end
            default: r_state_d = IDLE;
        endcase
    end

    // State, grant and round-robin history registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_gnt_q   <= GNT_DATA;
`ifdef CACHE_ARB_RR_EN
            r_last_gnt_q <= GNT_DATA;
`endif
        end else begin
            r_state_q <= r_state_d;
            r_gnt_q   <= r_gnt_d;
`ifdef CACHE_ARB_RR_EN
            r_last_gnt_q <= r_last_gnt_d;
`endif
        end
    end

    // Bus muxing and handshake steering; everything is forced to 0 outside its phase
    always_comb begin
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = 2'b00;
        mem_addr     = '0;
        mem_wdata    = '0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        case (r_state_q)
            ADDR: begin
                mem_req = w_gnt_req;
                if (r_gnt_q == GNT_DATA) begin
                    mem_wr       = data_wr;
                    mem_size     = data_size;
                    mem_addr     = data_addr;
                    mem_wdata    = data_wdata;
                    data_addr_ok = mem_addr_ok;
                end else begin
                    mem_size     = inst_size;
                    mem_addr     = inst_addr;
                    inst_addr_ok = mem_addr_ok;
                end
            end
            DATA: begin
                if (r_gnt_q == GNT_DATA) begin
                    data_data_ok = mem_data_ok;
                end else begin
                    inst_data_ok = mem_data_ok;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_bus_arbiter
// Description : Directed self-checking bench for cache_bus_arbiter with a
//               small sram-like bridge responder and two cache masters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inst_req = 1'b0;
    logic [1:0]    inst_size = 2'd2;
    logic [AW-1:0] inst_addr = '0;
    logic [DW-1:0] inst_rdata;
    logic          inst_addr_ok, inst_data_ok;
    logic          data_req = 1'b0;
    logic          data_wr = 1'b0;
    logic [1:0]    data_size = 2'd2;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic [DW-1:0] data_rdata;
    logic          data_addr_ok, data_data_ok;
    logic          mem_req, mem_wr;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_addr_ok, mem_data_ok;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cache_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
    );

    // Bridge responder: addr_ok after addr_wait cycles of mem_req, data_ok data_wait+1 cycles later
    int            addr_wait = 1;
    int            data_wait = 0;
    logic [DW-1:0] rd_val = '0;
    logic          inj_dok = 1'b0;
    logic          b_pend = 1'b0;
    logic          b_dok = 1'b0;
    int            b_rcnt = 0;
    int            b_dcnt = 0;

    assign mem_addr_ok = mem_req && !b_pend && (b_rcnt >= addr_wait);
    assign mem_data_ok = b_dok | inj_dok;
    assign mem_rdata   = rd_val;

    always begin : bridge
        logic s_hs, s_req, s_dok;
        @(negedge clk);
        s_hs  = mem_req && mem_addr_ok;
        s_req = mem_req;
        s_dok = b_dok;
        @(posedge clk);
        #2;
        if (rst) begin
            b_pend = 1'b0; b_dok = 1'b0; b_rcnt = 0; b_dcnt = 0;
        end else begin
            b_dok = 1'b0;
            if (s_dok) b_pend = 1'b0;
            if (s_hs) begin
                b_pend = 1'b1; b_dcnt = data_wait; b_rcnt = 0;
            end else begin
                b_rcnt = s_req ? b_rcnt + 1 : 0;
                if (b_pend && !s_dok) begin
                    if (b_dcnt == 0) b_dok = 1'b1;
                    else b_dcnt--;
                end
            end
        end
    end

    // Cache masters: hold req while transactions remain, advance address on each accept
    int            i_todo = 0, d_todo = 0, i_iss = 0, d_iss = 0;
    logic [AW-1:0] i_base = '0, d_base = '0;
    logic [DW-1:0] d_wbase = '0;

    always begin : masters
        logic s_ihs, s_dhs;
        @(negedge clk);
        s_ihs = inst_req && inst_addr_ok;
        s_dhs = data_req && data_addr_ok;
        @(posedge clk);
        #1;
        if (s_ihs) begin i_todo--; i_iss++; end
        if (s_dhs) begin d_todo--; d_iss++; end
        inst_req   = (i_todo > 0);
        inst_addr  = i_base + 32'(i_iss * 4);
        data_req   = (d_todo > 0);
        data_addr  = d_base + 32'(d_iss * 4);
        data_wdata = d_wbase + 32'(d_iss);
    end

    // Monitor: handshake counts, captured read data and grant order
    int            i_aok = 0, i_dok = 0, d_aok = 0, d_dok = 0;
    logic [DW-1:0] i_rd = '0, d_rd = '0;
    logic          hs_wr = 1'b0;
    logic [1:0]    hs_size = '0;
    logic [AW-1:0] hs_addr = '0;
    logic [DW-1:0] hs_wdata = '0;
    string         order = "";

    always @(negedge clk) begin
        if (inst_addr_ok) i_aok++;
        if (data_addr_ok) d_aok++;
        if (inst_data_ok) begin i_dok++; i_rd = inst_rdata; end
        if (data_data_ok) begin d_dok++; d_rd = data_rdata; end
        if (mem_req && mem_addr_ok) begin
            hs_wr = mem_wr; hs_size = mem_size; hs_addr = mem_addr; hs_wdata = mem_wdata;
            if (inst_addr_ok) order = {order, "I"};
            else order = {order, "D"};
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_str(input string tag, input string obs, input string exp);
        tests++;
        assert (obs == exp) else begin
            fails++;
            $error("FAIL %s: observed %s expected %s", tag, obs, exp);
        end
    endtask

    task automatic clear();
        i_aok = 0; i_dok = 0; d_aok = 0; d_dok = 0;
        i_rd = '0; d_rd = '0; order = "";
    endtask

    task automatic wait_dok(input int ei, input int ed, input string tag, output int cyc);
        cyc = 0;
        while ((i_dok < ei || d_dok < ed) && cyc < 200) begin
            step();
            cyc++;
        end
        check(tag, 32'(cyc < 200), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int cyc;
        int n;
        rd_val = 32'h1357_2468;
        repeat (2) step();

        // Reset values
        check("rst_mem_req",   32'(mem_req), 32'd0);
        check("rst_mem_wr",    32'(mem_wr), 32'd0);
        check("rst_mem_size",  32'(mem_size), 32'd0);
        check("rst_mem_addr",  mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_oks",       32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'd0);
        check("rst_inst_rdata", inst_rdata, 32'h1357_2468);
        check("rst_data_rdata", data_rdata, 32'h1357_2468);
        rst = 1'b0;
        step();

        // Single instruction read
        clear();
        rd_val = 32'h2408_0001; i_base = 32'hBFC0_0000; i_iss = 0; i_todo = 1;
        wait_dok(1, 0, "t1_timeout", cyc);
        step(); step();
        check("t1_latency", 32'(cyc), 32'd5);
        check("t1_mem_wr",  32'(hs_wr), 32'd0);
        check("t1_mem_addr", hs_addr, 32'hBFC0_0000);
        check("t1_mem_wdata", hs_wdata, 32'd0);
        check("t1_mem_size", 32'(hs_size), 32'd2);
        check("t1_inst_aok_cnt", 32'(i_aok), 32'd1);
        check("t1_inst_dok_cnt", 32'(i_dok), 32'd1);
        check("t1_inst_rdata", i_rd, 32'h2408_0001);
        check("t1_data_oks", 32'(d_aok + d_dok), 32'd0);

        // Single data write
        clear();
        data_wr = 1'b1; data_size = 2'd2;
        d_base = 32'h8000_1004; d_wbase = 32'hDEAD_BEEF; d_iss = 0; d_todo = 1;
        wait_dok(0, 1, "t2_timeout", cyc);
        step(); step();
        check("t2_latency", 32'(cyc), 32'd5);
        check("t2_mem_wr", 32'(hs_wr), 32'd1);
        check("t2_mem_wdata", hs_wdata, 32'hDEAD_BEEF);
        check("t2_mem_addr", hs_addr, 32'h8000_1004);
        check("t2_mem_size", 32'(hs_size), 32'd2);
        check("t2_data_dok_cnt", 32'(d_dok), 32'd1);
        check("t2_inst_oks", 32'(i_aok + i_dok), 32'd0);
        check("t2_state_idle", 32'(dut.r_state_q), 32'd0);
        check("t2_mem_req_idle", 32'(mem_req), 32'd0);

        // Simultaneous requests after reset
        do_reset();
        clear();
        data_wr = 1'b0;
        i_base = 32'hBFC0_0100; d_base = 32'h8000_0100; i_iss = 0; d_iss = 0;
        i_todo = 1; d_todo = 1;
        wait_dok(1, 1, "t3_timeout", cyc);
        check("t3_cycles", 32'(cyc), 32'd10);
`ifdef CACHE_ARB_RR_EN
        check_str("t3_order", order, "ID");
`else
        check_str("t3_order", order, "DI");
`endif

        // Four back-to-back transactions from each master
        clear();
        i_iss = 0; d_iss = 0; i_todo = 4; d_todo = 4;
        wait_dok(4, 4, "t4_timeout", cyc);
        check("t4_cycles", 32'(cyc), 32'd40);
        check("t4_aok_cnts", 32'({i_aok[15:0], d_aok[15:0]}), 32'h0004_0004);
`ifdef CACHE_ARB_RR_EN
        check_str("t4_order", order, "IDIDIDID");
        check("t4_last_addr", hs_addr, 32'h8000_010C);
`else
        check_str("t4_order", order, "DDDDIIII");
        check("t4_last_addr", hs_addr, 32'hBFC0_010C);
`endif

        // Bridge stalls address acceptance for five cycles
        clear();
        addr_wait = 5;
        d_base = 32'h8000_2000; d_iss = 0; d_todo = 1;
        n = 0;
        while (!mem_req && n < 20) begin step(); n++; end
        check("t5_req_seen", 32'(n < 20), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("t5_req_held", 32'(mem_req), 32'd1);
            check("t5_addr_stable", mem_addr, 32'h8000_2000);
            check("t5_no_aok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
            step();
        end
        check("t5_aok", 32'(data_addr_ok), 32'd1);
        addr_wait = 1;
        wait_dok(0, 1, "t5_timeout", cyc);
        check("t5_aok_cnt", 32'(d_aok), 32'd1);

        // Reset in DATA, late data_ok must be dropped
        clear();
        rd_val = 32'hCAFE_F00D;
        d_base = 32'h8000_3000; d_iss = 0; d_todo = 1;
        n = 0;
        while (d_aok == 0 && n < 50) begin step(); n++; end
        check("t6_aok_seen", 32'(n < 50), 32'd1);
        step();
        check("t6_in_data", 32'(dut.r_state_q), 32'd2);
        rst = 1'b1; d_todo = 0;
        #1;
        check("t6_async_idle", 32'(dut.r_state_q), 32'd0);
        check("t6_async_oks", 32'({mem_req, data_data_ok}), 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        inj_dok = 1'b1;
        #1;
        check("t6_late_dok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        step();
        inj_dok = 1'b0;
        check("t6_dok_cnt", 32'(i_dok + d_dok), 32'd0);
        check("t6_state_idle", 32'(dut.r_state_q), 32'd0);
        clear();
        d_iss = 0; d_todo = 1;
        wait_dok(0, 1, "t6_timeout", cyc);
        check("t6_next_latency", 32'(cyc), 32'd5);
        check("t6_next_rdata", d_rd, 32'hCAFE_F00D);
        check("t6_next_aok", 32'(d_aok), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
